// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares one single-port data memory between two requesters: instruction
//   fetch (IF, read-only) and load/store (LS, read/write). The memory has a
//   synchronous write and a registered read with one cycle of latency. Every
//   access is a fixed three-state sequence:
//     IDLE : grant a requester and register its command
//     CMD  : strobe the memory (only when the address is in range)
//     RESP : read data is available; register the response for the owner
//   The registered ack, rdata and err are visible in the cycle after RESP.
//   LS has priority. When LS has won STARVE_LIMIT contentions in a row, IF
//   wins the next one.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request and word address
//   if_ack/if_rdata/if_err   one-cycle fetch completion, data, range error
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, direction, address, data
//   ls_ack/ls_rdata/ls_err   one-cycle load/store completion, data, range error
//   mem_addr/mem_rd/mem_wr/mem_wdata  registered memory command
//   mem_rdata                memory read data (one cycle after mem_rd)
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
   parameter int DEPTH        = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0]  S_IDLE     = 2'd0;
   localparam logic [1:0]  S_CMD      = 2'd1;
   localparam logic [1:0]  S_RESP     = 2'd2;
   localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
   localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

   logic [1:0]  state_q, state_d;
   logic        owner_ls_q, owner_ls_d;
   logic        we_q, we_d;
   logic        oor_q, oor_d;
   logic [3:0]  starve_q, starve_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;
   logic        if_ack_q, if_ack_d;
   logic        ls_ack_q, ls_ack_d;
   logic        if_err_q, if_err_d;
   logic        ls_err_q, ls_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;

   logic        grant_ls;
   logic [31:0] sel_addr;
   logic        sel_we;
   logic        sel_in_range;
   logic [31:0] resp_data;

   // LS wins unless IF is also waiting and has already been passed over
   // STARVE_LIMIT times in a row.
   assign grant_ls     = ls_req && !(if_req && (starve_q == STARVE_MAX));
   assign sel_addr     = grant_ls ? ls_addr : if_addr;
   assign sel_we       = grant_ls && ls_we;
   // Full 32-bit compare: high address bits must not alias into the array.
   assign sel_in_range = (sel_addr < DEPTH_W);
   // Stores and out-of-range accesses return zero data.
   assign resp_data    = (!oor_q && !we_q) ? mem_rdata : 32'd0;

   always_comb begin
      state_d     = state_q;
      owner_ls_d  = owner_ls_q;
      we_d        = we_q;
      oor_d       = oor_q;
      starve_d    = starve_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      // Strobes and responses are single-cycle pulses unless set below.
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      if_ack_d    = 1'b0;
      ls_ack_d    = 1'b0;
      if_err_d    = 1'b0;
      ls_err_d    = 1'b0;
      if_rdata_d  = 32'd0;
      ls_rdata_d  = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (if_req || ls_req) begin
               state_d    = S_CMD;
               owner_ls_d = grant_ls;
               we_d       = sel_we;
               oor_d      = !sel_in_range;
               mem_addr_d = sel_addr;
               mem_rd_d   = sel_in_range && !sel_we;
               mem_wr_d   = sel_in_range && sel_we;
               if (sel_we) begin
                  mem_wdata_d = ls_wdata;
               end
               if (grant_ls && if_req) begin
                  starve_d = starve_q + 4'd1;
               end else begin
                  starve_d = 4'd0;
               end
            end
         end
         S_CMD: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (owner_ls_q) begin
               ls_ack_d   = 1'b1;
               ls_rdata_d = resp_data;
               ls_err_d   = oor_q;
            end else begin
               if_ack_d   = 1'b1;
               if_rdata_d = resp_data;
               if_err_d   = oor_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_ls_q  <= 1'b0;
         we_q        <= 1'b0;
         oor_q       <= 1'b0;
         starve_q    <= 4'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         if_ack_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         if_rdata_q  <= 32'd0;
         ls_rdata_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         owner_ls_q  <= owner_ls_d;
         we_q        <= we_d;
         oor_q       <= oor_d;
         starve_q    <= starve_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         if_ack_q    <= if_ack_d;
         ls_ack_q    <= ls_ack_d;
         if_err_q    <= if_err_d;
         ls_err_q    <= ls_err_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign if_ack    = if_ack_q;
   assign ls_ack    = ls_ack_q;
   assign if_err    = if_err_q;
   assign ls_err    = ls_err_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates one single-port 16-word data memory (sync write; registered read, 1-cycle latency) between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sequences each access as a fixed 3-cycle transaction: grant, command, response.
- Enforces address bounds.
- Data priority, with a starvation guard for fetch.

Parameters:
- DEPTH, 16, number of memory words; valid word address range 0..DEPTH-1.
- STARVE_LIMIT, 4, consecutive LS grants made while IF was waiting, after which IF wins the next contention; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- if_req  input  1  fetch request, held until if_ack
- if_addr  input  32  fetch word address
- if_ack  output  1  one-cycle completion pulse
- if_rdata  output  32  fetch data, valid only while if_ack=1
- if_err  output  1  out-of-range flag, valid only while if_ack=1
- ls_req  input  1  load/store request, held until ls_ack
- ls_we  input  1  1=store, 0=load
- ls_addr  input  32  word address
- ls_wdata  input  32  store data
- ls_ack  output  1  one-cycle completion pulse
- ls_rdata  output  32  load data, valid only while ls_ack=1
- ls_err  output  1  out-of-range flag, valid only while ls_ack=1
- mem_addr  output  32  to memory address (PC) input
- mem_rd  output  1  to memory rd
- mem_wr  output  1  to memory wr
- mem_wdata  output  32  to memory inputdata
- mem_rdata  input  32  from memory outputdata

Behaviour:
- FSM states: IDLE, CMD, RESP.
- Reset: state=IDLE. mem_rd, mem_wr, if_ack, ls_ack, if_err, ls_err = 0. mem_addr and mem_wdata = 0. if_rdata and ls_rdata = 0. starve_cnt=0.
- IDLE: if any request is high, capture owner, address, we and wdata into registers, then go to CMD. Otherwise stay in IDLE.
- Grant rule: LS only -> LS. IF only -> IF. Both high -> LS, unless starve_cnt==STARVE_LIMIT, in which case IF.
- starve_cnt update on each grant:
  - LS granted while if_req=1 -> starve_cnt+1.
  - IF granted, or LS granted while if_req=0 -> 0.
- CMD (one cycle):
  - mem_addr = captured address.
  - In range (addr < DEPTH): mem_rd=1 for reads/fetch, or mem_wr=1 with mem_wdata=captured wdata for stores.
  - Out of range: no strobe asserted.
  - Next state: RESP.
- RESP (one cycle):
  - Owner's ack=1.
  - rdata = mem_rdata for an in-range read, 0 for stores and errors.
  - err = 1 if out of range.
  - Next state: IDLE.
  - The non-owner's ack, rdata and err stay 0.
- Latency: request sampled high in IDLE at edge N -> ack high in the cycle following edge N+2. Max throughput is one transaction per 3 cycles.
- Strobes are registered, and are high for exactly the CMD cycle only.
- Requester protocol: req and its payload stay stable from assertion until ack. The requester drops req (or presents a new request) after the ack cycle. Requests arriving in CMD or RESP wait for IDLE. Payload changes during a pending req are a protocol violation and are ignored after capture.
- Address compare uses the full 32-bit value. Addresses >= DEPTH never strobe the memory.
- Reset mid-transaction: FSM returns to IDLE, no ack is issued, and all outputs return to reset values. A store whose CMD cycle coincides with rst=1 still commits (memory is not reset) but is never acked.
- Simultaneous ack of both requesters is impossible; at most one ack per RESP.

Test Plan:
- Reset then store LS addr 3 data 0xDEADBEEF, then IF fetch addr 3 -> mem_wr high in one cycle only; IF ack 3 cycles after sampling, if_rdata=0xDEADBEEF, if_err=0.
- LS load addr 20 -> mem_rd and mem_wr never high; ls_ack with ls_err=1 and ls_rdata=0.
- if_req and ls_req held high continuously, STARVE_LIMIT=4 -> grant sequence LS,LS,LS,LS,IF repeating; acks spaced exactly 3 cycles apart.
- ls_req only, back-to-back loads addrs 0..15 preloaded with value=addr*2 -> each ls_rdata matches; if_ack never asserts.
- rst asserted during RESP of a pending IF fetch -> no if_ack; all outputs 0 next cycle; a new request completes normally.
- rst asserted during the CMD cycle of store addr 5 data 0x1234 -> no ls_ack; a later fetch of addr 5 returns 0x1234.
